alu_dispatch: RTL

Upstream sequencer for the ALU functional units (comparator, adder, etc.). Accepts an opcode and two 4-bit operands from the host on a start pulse, packs them onto the shared 8-bit unit data bus, and runs the enable/done handshake with the selected unit. Captures the unit's result and returns it with a one-cycle valid strobe. Flags an error on timeout or an unsupported opcode.

---
 rtl/alu_pkg.sv | 8 +
 rtl/sync_bit.sv | 16 +
 rtl/alu_dispatch.sv | 89 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared dispatcher state encoding and functional-unit opcode constants
package alu_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ASSERT, ST_RELEASE, ST_RESPOND} state_t;
  localparam logic [1:0] OP_COMP = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_MUL  = 2'd3;
endpackage

// File: rtl/sync_bit.sv
// sync_bit: SYNC-deep flop chain bringing an asynchronous level into the clk domain
// Ports: clk, rst_n (async active-low), i_d raw level, o_q synchronized level
module sync_bit #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC-1:0] r_sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sync <= '0;
    else r_sync <= {r_sync[SYNC-2:0], i_d};
  assign o_q = r_sync[SYNC-1];
endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch: sequences one host request through an enable/done handshake with a selected ALU unit
// Ports: host side start/opcode/a_in/b_in in, busy/result/result_valid/err out;
//        unit side data_out/unit_en out, unit_done (async levels)/unit_result in
module alu_dispatch import alu_pkg::*; #(
  parameter int NUNITS  = 4,
  parameter int OPW     = 2,
  parameter int RW      = 8,
  parameter int TIMEOUT = 64,
  parameter int SYNC    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [OPW-1:0]       opcode,
  input  logic [3:0]           a_in,
  input  logic [3:0]           b_in,
  output logic                 busy,
  output logic [7:0]           data_out,
  output logic [NUNITS-1:0]    unit_en,
  input  logic [NUNITS-1:0]    unit_done,
  input  logic [NUNITS*RW-1:0] unit_result,
  output logic [RW-1:0]        result,
  output logic                 result_valid,
  output logic                 err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t            r_state, w_next;
  logic [OPW-1:0]    r_op;
  logic [TW-1:0]     r_timer;
  logic [RW-1:0]     r_latch, w_res;
  logic [NUNITS-1:0] w_sync, w_sel;
  logic              w_done, w_tmo, w_acc, w_bad, w_wait;
  for (genvar i = 0; i < NUNITS; i++) begin : g_sync
    sync_bit #(.SYNC(SYNC)) u_sync (.clk(clk), .rst_n(rst_n), .i_d(unit_done[i]), .o_q(w_sync[i]));
  end
  // Selection is masked so done levels from other units never reach the FSM
  assign w_sel  = NUNITS'(1) << r_op;
  assign w_done = |(w_sync & w_sel);
  assign w_acc  = (r_state == ST_IDLE) && start;
  assign w_bad  = 32'(opcode) >= NUNITS;
  assign w_wait = (r_state == ST_ASSERT) || (r_state == ST_RELEASE);
  // Abort on the TIMEOUT-th cycle spent waiting in the current state
  assign w_tmo  = r_timer == TW'(TIMEOUT - 1);
  always_comb begin
    w_res = '0;
    for (int k = 0; k < NUNITS; k++) w_res = w_sel[k] ? unit_result[k*RW +: RW] : w_res;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next = w_bad ? ST_RESPOND : ST_SETUP;
      ST_SETUP:   w_next = ST_ASSERT;
      ST_ASSERT:  if (w_done || w_tmo) w_next = w_done ? ST_RELEASE : ST_RESPOND;
      ST_RELEASE: if (!w_done || w_tmo) w_next = ST_RESPOND;
      default:    w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_op         <= '0;
      r_timer      <= '0;
      r_latch      <= '0;
      busy         <= 1'b0;
      data_out     <= '0;
      unit_en      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      r_state <= w_next;
      r_timer <= (w_next != r_state || !w_wait) ? '0 : (r_timer == TW'(TIMEOUT)) ? r_timer : r_timer + 1'b1;
      if (w_acc) begin
        r_op    <= opcode;
        r_latch <= '0;
        err     <= 1'b0;
      end
      if (w_acc && !w_bad) data_out <= {a_in, b_in};
      if (r_state == ST_ASSERT && w_done) r_latch <= w_res;
      busy         <= w_next != ST_IDLE;
      unit_en      <= (w_next == ST_ASSERT) ? w_sel : '0;
      result_valid <= w_next == ST_RESPOND;
      // Reaching RESPOND from anywhere but a clean RELEASE (done seen low) is an error
      if (w_next == ST_RESPOND) begin
        result <= (r_state == ST_IDLE) ? '0 : r_latch;
        err    <= (r_state != ST_RELEASE) || w_done;
      end
    end
endmodule
